// File: rtl/kun16_mmio_pkg.sv
// ============================================================================
// kun16_mmio_pkg : register offsets and bit positions for the KUN16 MMIO block
// Revision 1.0
// ============================================================================
`default_nettype none

package kun16_mmio_pkg;

  localparam logic [3:0] OFS_TXDATA = 4'h0;
  localparam logic [3:0] OFS_RXDATA = 4'h2;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_TIMER  = 4'h6;
  localparam logic [3:0] OFS_TCMP   = 4'h8;
  localparam logic [3:0] OFS_CTRL   = 4'hA;

  localparam int ST_TX_EMPTY = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_MATCH    = 5;
  localparam int ST_TX_DROP  = 6;

  localparam int CTRL_TIMER_EN     = 0;
  localparam int CTRL_IRQ_EN_MATCH = 1;
  localparam int CTRL_IRQ_EN_RX    = 2;
  localparam int CTRL_W            = 3;

endpackage

`default_nettype wire

// File: rtl/kun16_sync_fifo.sv
// ============================================================================
// kun16_sync_fifo : single-clock FIFO; a push into a full FIFO is accepted
// only when a pop happens on the same edge. Revision 1.0
// ============================================================================
`default_nettype none

module kun16_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);
  // Empty FIFO presents zero so consumers never see stale storage.
  assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/kun16_mmio_responder.sv
// ============================================================================
// kun16_mmio_responder : 16-byte MMIO window with TX/RX byte FIFOs, a
// compare timer and a level interrupt. Revision 1.0
// ============================================================================
`default_nettype none

module kun16_mmio_responder
  import kun16_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mmio_addr,
  input  logic        mmio_wen,
  input  logic        mmio_ren,
  input  logic [15:0] mmio_wdata,
  output logic [15:0] mmio_rdata,
  output logic        mmio_hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  logic [3:0]        w_ofs;
  logic              w_wr, w_rd;
  logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic              w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]        w_rx_head;
  logic              w_wr_status, w_match_set, w_tx_drop_set;
  logic              w_unused_addr_lsb;
  logic [15:0]       w_status;

  logic [15:0]       count_q, count_d;
  logic [15:0]       tcmp_q, tcmp_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              match_q, match_d;
  logic              tx_drop_q, tx_drop_d;

  // Registers are 16-bit aligned; the byte-select bit plays no part in decode.
  assign w_unused_addr_lsb = mmio_addr[0];
  assign w_ofs    = {mmio_addr[3:1], 1'b0};
  assign mmio_hit = (mmio_addr[15:4] == BASE_ADDR[15:4]);
  assign w_wr     = mmio_hit & mmio_wen;
  assign w_rd     = mmio_hit & mmio_ren;

  assign tx_valid      = ~w_tx_empty;
  assign w_tx_pop      = tx_valid & tx_ready;
  assign w_tx_push     = w_wr & (w_ofs == OFS_TXDATA);
  assign w_tx_drop_set = w_tx_push & w_tx_full & ~w_tx_pop;

  assign rx_ready  = ~w_rx_full;
  assign w_rx_push = rx_valid & rx_ready;
  assign w_rx_pop  = w_rd & (w_ofs == OFS_RXDATA) & ~w_rx_empty;

  kun16_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_tx_push),
    .din_i   (mmio_wdata[7:0]),
    .pop_i   (w_tx_pop),
    .full_o  (w_tx_full),
    .empty_o (w_tx_empty),
    .head_o  (tx_data)
  );

  kun16_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_rx_push),
    .din_i   (rx_data),
    .pop_i   (w_rx_pop),
    .full_o  (w_rx_full),
    .empty_o (w_rx_empty),
    .head_o  (w_rx_head)
  );

  assign w_wr_status = w_wr & (w_ofs == OFS_STATUS);
  assign w_match_set = ctrl_q[CTRL_TIMER_EN] & (count_q == tcmp_q);

  // OR-ing the set term after the clear makes a coincident set win.
  always_comb begin
    count_d   = count_q;
    tcmp_d    = tcmp_q;
    ctrl_d    = ctrl_q;
    match_d   = (match_q & ~(w_wr_status & mmio_wdata[ST_MATCH])) | w_match_set;
    tx_drop_d = (tx_drop_q & ~(w_wr_status & mmio_wdata[ST_TX_DROP])) | w_tx_drop_set;
    if (w_wr && (w_ofs == OFS_TIMER))       count_d = mmio_wdata;
    else if (ctrl_q[CTRL_TIMER_EN])         count_d = count_q + 16'd1;
    if (w_wr && (w_ofs == OFS_TCMP))        tcmp_d  = mmio_wdata;
    if (w_wr && (w_ofs == OFS_CTRL))        ctrl_d  = mmio_wdata[CTRL_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      tcmp_q    <= '0;
      ctrl_q    <= '0;
      match_q   <= 1'b0;
      tx_drop_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tcmp_q    <= tcmp_d;
      ctrl_q    <= ctrl_d;
      match_q   <= match_d;
      tx_drop_q <= tx_drop_d;
    end
  end

  always_comb begin
    w_status              = '0;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_MATCH]    = match_q;
    w_status[ST_TX_DROP]  = tx_drop_q;
  end

  always_comb begin
    mmio_rdata = '0;
    if (mmio_hit) begin
      case (w_ofs)
        OFS_RXDATA: mmio_rdata = {8'h00, w_rx_head};
        OFS_STATUS: mmio_rdata = w_status;
        OFS_TIMER:  mmio_rdata = count_q;
        OFS_TCMP:   mmio_rdata = tcmp_q;
        OFS_CTRL:   mmio_rdata = {{(16-CTRL_W){1'b0}}, ctrl_q};
        default:    mmio_rdata = '0;
      endcase
    end
  end

  assign irq = (match_q & ctrl_q[CTRL_IRQ_EN_MATCH]) |
               (~w_rx_empty & ctrl_q[CTRL_IRQ_EN_RX]);

endmodule

`default_nettype wire

// File: tb/tb_kun16_mmio_responder.sv
// ============================================================================
// tb_kun16_mmio_responder : directed vector table plus hand-written sequences
// for FIFO, timer and reset corner cases. Revision 1.0
// ============================================================================
`default_nettype none

module tb_kun16_mmio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mmio_addr, mmio_wdata, mmio_rdata;
  logic        mmio_wen, mmio_ren, mmio_hit;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  localparam logic [15:0] A_TX = 16'hFF00;
  localparam logic [15:0] A_RX = 16'hFF02;
  localparam logic [15:0] A_ST = 16'hFF04;
  localparam logic [15:0] A_TM = 16'hFF06;
  localparam logic [15:0] A_TC = 16'hFF08;
  localparam logic [15:0] A_CT = 16'hFF0A;

  kun16_mmio_responder #(.BASE_ADDR(16'hFF00), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mmio_addr  (mmio_addr),
    .mmio_wen   (mmio_wen),
    .mmio_ren   (mmio_ren),
    .mmio_wdata (mmio_wdata),
    .mmio_rdata (mmio_rdata),
    .mmio_hit   (mmio_hit),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] rd;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  localparam int NV = 21;
  vec_t vec [NV];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    mmio_addr = a; mmio_wdata = d; mmio_wen = 1'b1; mmio_ren = 1'b0;
    @(posedge clk);
    #1 mmio_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    mmio_addr = a; mmio_wen = 1'b0; mmio_ren = 1'b1;
    #1 d = mmio_rdata;
    @(posedge clk);
    #1 mmio_ren = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    mmio_addr = a; mmio_wen = 1'b0; mmio_ren = 1'b0;
    #1 d = mmio_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec[0]  = '{1'b1, 1'b0, 16'hFF08, 16'h1234, 16'h0000, 1'b1};
    vec[1]  = '{1'b0, 1'b1, 16'hFF08, 16'h0000, 16'h1234, 1'b1};
    vec[2]  = '{1'b1, 1'b0, 16'hFF0A, 16'hFFF8, 16'h0000, 1'b1};
    vec[3]  = '{1'b0, 1'b1, 16'hFF0A, 16'h0000, 16'h0000, 1'b1};
    vec[4]  = '{1'b1, 1'b0, 16'hFF0A, 16'h0006, 16'h0000, 1'b1};
    vec[5]  = '{1'b0, 1'b1, 16'hFF0B, 16'h0000, 16'h0006, 1'b1};
    vec[6]  = '{1'b1, 1'b0, 16'hFF0A, 16'h0000, 16'h0006, 1'b1};
    vec[7]  = '{1'b0, 1'b1, 16'hFF0C, 16'h0000, 16'h0000, 1'b1};
    vec[8]  = '{1'b1, 1'b0, 16'hFF0E, 16'hFFFF, 16'h0000, 1'b1};
    vec[9]  = '{1'b0, 1'b1, 16'hFF0E, 16'h0000, 16'h0000, 1'b1};
    vec[10] = '{1'b1, 1'b0, 16'hFE08, 16'hBEEF, 16'h0000, 1'b0};
    vec[11] = '{1'b0, 1'b1, 16'hFF08, 16'h0000, 16'h1234, 1'b1};
    vec[12] = '{1'b0, 1'b1, 16'hFE08, 16'h0000, 16'h0000, 1'b0};
    vec[13] = '{1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0005, 1'b1};
    vec[14] = '{1'b0, 1'b1, 16'hFF00, 16'h0000, 16'h0000, 1'b1};
    vec[15] = '{1'b0, 1'b1, 16'hFF02, 16'h0000, 16'h0000, 1'b1};
    vec[16] = '{1'b1, 1'b0, 16'hFF06, 16'h0042, 16'h0000, 1'b1};
    vec[17] = '{1'b0, 1'b1, 16'hFF06, 16'h0000, 16'h0042, 1'b1};
    vec[18] = '{1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0005, 1'b1};
    vec[19] = '{1'b1, 1'b0, 16'hFF04, 16'hFFFF, 16'h0005, 1'b1};
    vec[20] = '{1'b0, 1'b1, 16'hFF04, 16'h0000, 16'h0005, 1'b1};

    rst = 1'b1; mmio_addr = 16'h0000; mmio_wdata = 16'h0000;
    mmio_wen = 1'b0; mmio_ren = 1'b0; tx_ready = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0;
    #12;
    check("rst tx_valid", {15'd0, tx_valid}, 16'd0);
    check("rst tx_data", {8'd0, tx_data}, 16'd0);
    check("rst rx_ready", {15'd0, rx_ready}, 16'd1);
    check("rst irq", {15'd0, irq}, 16'd0);
    check("rst rdata", mmio_rdata, 16'd0);
    @(negedge clk) rst = 1'b0;

    // Register-level vectors: rdata/hit checked before the committing edge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      mmio_wen = vec[i].wen; mmio_ren = vec[i].ren;
      mmio_addr = vec[i].addr; mmio_wdata = vec[i].wdata;
      #1;
      check($sformatf("vec%0d rdata", i), mmio_rdata, vec[i].exp_rdata);
      check($sformatf("vec%0d hit", i), {15'd0, mmio_hit}, {15'd0, vec[i].exp_hit});
    end
    @(negedge clk) begin mmio_wen = 1'b0; mmio_ren = 1'b0; end

    // TX basic push and drain
    bus_write(A_TX, 16'h00A5);
    bus_write(A_TX, 16'h005A);
    peek(A_ST, rd);
    check("tx2 status", rd, 16'h0004);
    check("tx2 valid", {15'd0, tx_valid}, 16'd1);
    check("tx2 head", {8'd0, tx_data}, 16'h00A5);
    @(negedge clk) tx_ready = 1'b1;
    #1 check("drain0", {8'd0, tx_data}, 16'h00A5);
    @(negedge clk);
    #1 check("drain1", {7'd0, tx_valid, tx_data}, 16'h015A);
    @(negedge clk);
    #1 check("drained valid", {15'd0, tx_valid}, 16'd0);
    tx_ready = 1'b0;

    // TX overflow: ninth byte dropped, tx_drop sticky until W1C
    for (int i = 0; i < 9; i++) bus_write(A_TX, 16'h0010 + 16'(i));
    peek(A_ST, rd);
    check("ovf status", rd, 16'h0046);
    bus_write(A_ST, 16'h0040);
    peek(A_ST, rd);
    check("drop clr status", rd, 16'h0006);
    @(negedge clk) tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("ovf drain%0d", i), {7'd0, tx_valid, tx_data}, 16'h0110 + 16'(i));
      @(negedge clk);
    end
    #1 check("ovf empty", {15'd0, tx_valid}, 16'd0);
    tx_ready = 1'b0;

    // Push into full FIFO with a same-edge drain is accepted
    for (int i = 0; i < 8; i++) bus_write(A_TX, 16'h0020 + 16'(i));
    @(negedge clk);
    mmio_addr = A_TX; mmio_wdata = 16'h0028; mmio_wen = 1'b1; tx_ready = 1'b1;
    @(posedge clk);
    #1 begin mmio_wen = 1'b0; tx_ready = 1'b0; end
    peek(A_ST, rd);
    check("full push+drain status", rd, 16'h0006);
    @(negedge clk) tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("pd drain%0d", i), {7'd0, tx_valid, tx_data}, 16'h0121 + 16'(i));
      @(negedge clk);
    end
    tx_ready = 1'b0;

    // RX fill to full, offer one more, then pops
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rx_data = 8'h11 + 8'(i); rx_valid = 1'b1;
      #1 check($sformatf("rx ready%0d", i), {15'd0, rx_ready}, 16'd1);
    end
    @(negedge clk) rx_data = 8'h19;
    #1 check("rx full ready", {15'd0, rx_ready}, 16'd0);
    peek(A_ST, rd);
    check("rx full status", rd, 16'h0009);
    @(negedge clk) rx_valid = 1'b0;
    bus_read(A_RX, rd);
    check("rx pop0", rd, 16'h0011);
    check("rx ready after pop", {15'd0, rx_ready}, 16'd1);
    @(negedge clk);
    rx_data = 8'h19; rx_valid = 1'b1; mmio_addr = A_RX; mmio_ren = 1'b1;
    #1 check("rx cap+pop rdata", mmio_rdata, 16'h0012);
    @(posedge clk);
    #1 begin rx_valid = 1'b0; mmio_ren = 1'b0; end
    for (int i = 0; i < 7; i++) begin
      bus_read(A_RX, rd);
      check($sformatf("rx pop%0d", i + 2), rd, 16'h0013 + 16'(i));
    end
    bus_read(A_RX, rd);
    check("rx empty read", rd, 16'h0000);
    peek(A_ST, rd);
    check("rx empty status", rd, 16'h0005);
    @(negedge clk) begin rx_data = 8'h2A; rx_valid = 1'b1; end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    check("irq rx disabled", {15'd0, irq}, 16'd0);
    bus_write(A_CT, 16'h0004);
    check("irq rx", {15'd0, irq}, 16'd1);
    bus_read(A_RX, rd);
    check("rx after underflow", rd, 16'h002A);
    check("irq rx cleared", {15'd0, irq}, 16'd0);
    bus_write(A_CT, 16'h0000);

    // Timer compare and match interrupt
    bus_write(A_TC, 16'h0005);
    bus_write(A_TM, 16'h0000);
    bus_write(A_CT, 16'h0003);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      peek(A_TM, rd);
      check($sformatf("count%0d", i), rd, 16'(i));
      check($sformatf("irq pre%0d", i), {15'd0, irq}, 16'd0);
    end
    @(negedge clk);
    peek(A_TM, rd);
    check("count6", rd, 16'h0006);
    check("irq match", {15'd0, irq}, 16'd1);
    peek(A_ST, rd);
    check("match status", rd, 16'h0025);
    bus_write(A_ST, 16'h0020);
    check("irq after w1c", {15'd0, irq}, 16'd0);
    peek(A_ST, rd);
    check("w1c status", rd, 16'h0005);

    bus_write(A_TM, 16'hFFFF);
    peek(A_TM, rd);
    check("timer ffff", rd, 16'hFFFF);
    @(posedge clk);
    #1 peek(A_TM, rd);
    check("timer wrap", rd, 16'h0000);

    bus_write(A_TM, 16'h0100);
    peek(A_TM, rd);
    check("timer write wins", rd, 16'h0100);

    bus_write(A_ST, 16'h0060);
    bus_write(A_TM, 16'h0004);
    peek(A_ST, rd);
    check("pre coincide status", rd, 16'h0005);
    @(posedge clk);
    bus_write(A_ST, 16'h0020);
    peek(A_ST, rd);
    check("set beats clear", rd, 16'h0025);
    check("irq set beats clear", {15'd0, irq}, 16'd1);

    bus_write(A_CT, 16'h0000);
    bus_write(A_TM, 16'h0777);
    repeat (3) @(posedge clk);
    #1 peek(A_TM, rd);
    check("timer hold", rd, 16'h0777);
    bus_write(A_ST, 16'h0060);

    // Asynchronous reset in the middle of TX/RX traffic
    for (int i = 0; i < 4; i++) bus_write(A_TX, 16'h0030 + 16'(i));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) begin rx_data = 8'h40 + 8'(i); rx_valid = 1'b1; end
    end
    @(negedge clk) rx_valid = 1'b0;
    bus_write(A_CT, 16'h0007);
    peek(A_ST, rd);
    check("half status", rd, 16'h0000);
    check("half irq", {15'd0, irq}, 16'd1);
    @(negedge clk);
    mmio_addr = A_TX; mmio_wdata = 16'h0099; mmio_wen = 1'b1;
    rx_data = 8'h55; rx_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst tx_valid", {15'd0, tx_valid}, 16'd0);
    check("arst tx_data", {8'd0, tx_data}, 16'd0);
    check("arst rx_ready", {15'd0, rx_ready}, 16'd1);
    check("arst irq", {15'd0, irq}, 16'd0);
    mmio_wen = 1'b0; mmio_ren = 1'b0; rx_valid = 1'b0; mmio_addr = 16'h0000;
    #1 check("arst rdata", mmio_rdata, 16'd0);
    @(negedge clk) rst = 1'b0;
    peek(A_ST, rd);
    check("post rst status", rd, 16'h0005);
    peek(A_CT, rd);
    check("post rst ctrl", rd, 16'h0000);
    peek(A_TM, rd);
    check("post rst timer", rd, 16'h0000);
    peek(A_TC, rd);
    check("post rst tcmp", rd, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
